// File: rtl/data_mem_ctrl_pkg.sv
// Shared funct3 codes, controller state encoding and the misalignment rule
// for the data-memory controller.
package data_mem_ctrl_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB   = 3'b000;
    localparam logic [2:0] F3_LH   = 3'b001;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_LBU  = 3'b100;
    localparam logic [2:0] F3_LHU  = 3'b101;
    localparam logic [2:0] F3_BYTE = 3'b000;
    localparam logic [2:0] F3_SH   = 3'b001;
    localparam logic [2:0] F3_SW   = 3'b010;

    typedef enum logic [1:0] {
        DMC_IDLE      = 2'd0,
        DMC_STORE     = 2'd1,
        DMC_READ_WAIT = 2'd2,
        DMC_RESP      = 2'd3
    } dmc_state_t;

    // Store funct3 codes alias the load ones, so one rule covers both directions.
    function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] off);
        logic half_acc;
        logic word_acc;
        half_acc = (func3 == F3_LH) || (func3 == F3_LHU);
        word_acc = (func3 == F3_LW);
        return (half_acc && off[0]) || (word_acc && (off != 2'b00));
    endfunction

endpackage

// File: rtl/data_mem_ctrl_load_data_aligner.sv
// Combinational load-data aligner: selects the addressed byte/half/word from a
// BRAM word and sign- or zero-extends it according to funct3.
module load_data_aligner
    import data_mem_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      off,
    input  logic [2:0]      func3,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{off, 3'b000} +: 8];
        half_sel = rdata[{off[1], 4'b0000} +: 16];
        result   = '0;
        case (func3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {24'd0, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  result = {16'd0, half_sel};
            F3_LW:   result = rdata;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory access controller between the store-lane decoder and the data BRAM.
// Optional misalignment trapping is enabled with `define MEM_MISALIGN_EXC_EN.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_func3,
    input  logic [3:0]            req_byte_enb,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  stall,
    output logic                  bram_en,
    output logic [3:0]            bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_wdata,
    input  logic [DATA_WIDTH-1:0] bram_rdata
`ifdef MEM_MISALIGN_EXC_EN
    ,
    output logic                  misalign_err
`endif
);

    localparam logic [1:0] LAST_WAIT = 2'(READ_LATENCY - 1);

    dmc_state_t            state;
    dmc_state_t            state_next;
    logic                  accept;
    logic [1:0]            off_q;
    logic [2:0]            func3_q;
    logic [1:0]            wait_cnt;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] aligned;
    logic                  mis_now;
    logic                  mis_q;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^req_addr[DATA_WIDTH-1:ADDR_WIDTH+2];

    // Gating with rst_n drops BRAM strobes the moment reset asserts, even if req_valid is held.
    assign accept = (state == DMC_IDLE) && req_valid && rst_n;

`ifdef MEM_MISALIGN_EXC_EN
    assign mis_now      = is_misaligned(req_func3, req_addr[1:0]);
    assign misalign_err = mis_q && ((state == DMC_STORE) || (state == DMC_RESP));
`else
    assign mis_now = 1'b0;
`endif

    load_data_aligner u_aligner (
        .rdata  (rdata_q),
        .off    (off_q),
        .func3  (func3_q),
        .result (aligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= DMC_IDLE;
            off_q    <= '0;
            func3_q  <= '0;
            mis_q    <= 1'b0;
            wait_cnt <= '0;
            rdata_q  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                off_q   <= req_addr[1:0];
                func3_q <= req_func3;
                mis_q   <= mis_now;
            end
            wait_cnt <= (state == DMC_READ_WAIT) ? wait_cnt + 2'd1 : 2'd0;
            // Read data is captured on its valid cycle so RESP does not rely on BRAM output hold.
            if ((state == DMC_READ_WAIT) && (wait_cnt == LAST_WAIT)) begin
                rdata_q <= bram_rdata;
            end
        end
    end

    // The core is released on every rsp_valid cycle, so only load acceptance and READ_WAIT stall.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_rdata  = '0;
        stall      = 1'b0;
        bram_en    = 1'b0;
        bram_we    = 4'b0000;
        bram_addr  = '0;
        bram_wdata = '0;
        case (state)
            DMC_IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    bram_en   = 1'b1;
                    bram_addr = req_addr[ADDR_WIDTH+1:2];
                    if (req_we) begin
                        bram_we    = req_byte_enb & {4{~mis_now}};
                        bram_wdata = req_wdata;
                        state_next = DMC_STORE;
                    end else begin
                        stall      = 1'b1;
                        state_next = DMC_READ_WAIT;
                    end
                end
            end
            DMC_STORE: begin
                rsp_valid  = 1'b1;
                state_next = DMC_IDLE;
            end
            DMC_READ_WAIT: begin
                stall = 1'b1;
                if (wait_cnt == LAST_WAIT) begin
                    state_next = DMC_RESP;
                end
            end
            DMC_RESP: begin
                rsp_valid  = 1'b1;
                rsp_rdata  = mis_q ? '0 : aligned;
                state_next = DMC_IDLE;
            end
            default: state_next = DMC_IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl with a behavioural 1-cycle BRAM.
// Misalignment checks follow `define MEM_MISALIGN_EXC_EN, like the design.
module tb_data_mem_ctrl;
    import data_mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_func3 = '0;
    logic [3:0]  req_byte_enb = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        stall;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [11:0] bram_addr;
    logic [31:0] bram_wdata;
    logic [31:0] bram_rdata;
`ifdef MEM_MISALIGN_EXC_EN
    logic        misalign_err;
`endif

    logic [31:0] mem [0:4095];

    int checks = 0;
    int errors = 0;
    logic        mis_seen;

    data_mem_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_func3    (req_func3),
        .req_byte_enb (req_byte_enb),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .stall        (stall),
        .bram_en      (bram_en),
        .bram_we      (bram_we),
        .bram_addr    (bram_addr),
        .bram_wdata   (bram_wdata),
        .bram_rdata   (bram_rdata)
`ifdef MEM_MISALIGN_EXC_EN
        ,
        .misalign_err (misalign_err)
`endif
    );

    always #5 clk = ~clk;

    // Read-first BRAM with one cycle of read latency and byte write enables.
    always @(posedge clk) begin
        if (bram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
            end
            bram_rdata <= mem[bram_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Issues one request starting just after a rising edge and follows it to rsp_valid.
    task automatic applyStimulus(input string tag, input logic we, input logic [31:0] addr,
                                 input logic [2:0] f3, input logic [3:0] be, input logic [31:0] wdata,
                                 output logic [31:0] rd, output int lat, output int stl,
                                 output logic [3:0] we_seen, output logic [11:0] addr_seen);
        bit done;
        checkOutput({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr;
        req_func3 = f3; req_byte_enb = be; req_wdata = wdata;
        #1;
        we_seen = bram_we; addr_seen = bram_addr;
        stl = stall ? 1 : 0;
        lat = 0; rd = '0; done = 0; mis_seen = 1'b0;
        while (!done && lat < 8) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            lat++;
            if (rsp_valid) begin
                rd = rsp_rdata;
                done = 1;
`ifdef MEM_MISALIGN_EXC_EN
                mis_seen = misalign_err;
`endif
            end else begin
                stl += stall ? 1 : 0;
            end
        end
        if (!done) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        checkOutput({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic doLoad(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] exp);
        logic [31:0] rd; int lat; int stl; logic [3:0] wes; logic [11:0] ads;
        applyStimulus(tag, 1'b0, addr, f3, 4'b0000, 32'h0, rd, lat, stl, wes, ads);
        checkOutput({tag, "_data"}, rd, exp);
        checkOutput({tag, "_lat"}, 32'(lat), 32'd2);
        checkOutput({tag, "_stall"}, 32'(stl), 32'd2);
        checkOutput({tag, "_we"}, 32'(wes), 32'd0);
        checkOutput({tag, "_addr"}, 32'(ads), 32'(addr[13:2]));
    endtask

    task automatic doStore(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [3:0] be, input logic [31:0] wdata,
                           input logic [3:0] exp_we, input logic [11:0] exp_addr);
        logic [31:0] rd; int lat; int stl; logic [3:0] wes; logic [11:0] ads;
        applyStimulus(tag, 1'b1, addr, f3, be, wdata, rd, lat, stl, wes, ads);
        checkOutput({tag, "_we"}, 32'(wes), 32'(exp_we));
        checkOutput({tag, "_addr"}, 32'(ads), 32'(exp_addr));
        checkOutput({tag, "_lat"}, 32'(lat), 32'd1);
        checkOutput({tag, "_stall"}, 32'(stl), 32'd0);
        checkOutput({tag, "_rdata"}, rd, 32'd0);
    endtask

    initial begin
        #2;
        checkOutput("rst_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_rsp", 32'(rsp_valid), 32'd0);
        checkOutput("rst_en", 32'(bram_en), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        doStore("sw_beef", 32'h10, F3_SW, 4'b1111, 32'hDEADBEEF, 4'b1111, 12'd4);
        doLoad("lw_beef", 32'h10, F3_LW, 32'hDEADBEEF);
        doStore("sw_word", 32'h10, F3_SW, 4'b1111, 32'h80FF1234, 4'b1111, 12'd4);
        doLoad("lb_13", 32'h13, F3_LB, 32'hFFFFFF80);
        doLoad("lbu_13", 32'h13, F3_LBU, 32'h00000080);
        doLoad("lh_12", 32'h12, F3_LH, 32'hFFFF80FF);
        doLoad("lhu_12", 32'h12, F3_LHU, 32'h000080FF);
        doLoad("lw_10", 32'h10, F3_LW, 32'h80FF1234);
        checkOutput("lw_10_mis", 32'(mis_seen), 32'd0);
        doLoad("lb_10", 32'h10, F3_LB, 32'h00000034);
        doLoad("lb_12", 32'h12, F3_LB, 32'hFFFFFFFF);
        doLoad("lh_10", 32'h10, F3_LH, 32'h00001234);
        doLoad("f3_bad", 32'h10, 3'b011, 32'h00000000);

        doStore("sb_be0", 32'h10, F3_BYTE, 4'b0000, 32'h000000AA, 4'b0000, 12'd4);
        doLoad("sb_be0_rb", 32'h10, F3_LW, 32'h80FF1234);

        doStore("sw_wrap", 32'hFFFFC008, F3_SW, 4'b1111, 32'h0BADF00D, 4'b1111, 12'd2);
        doLoad("lw_wrap_rb", 32'h8, F3_LW, 32'h0BADF00D);

`ifdef MEM_MISALIGN_EXC_EN
        doLoad("lw_mis", 32'h11, F3_LW, 32'h00000000);
        checkOutput("lw_mis_err", 32'(mis_seen), 32'd1);
        doStore("sw_mis", 32'h12, F3_SW, 4'b1111, 32'h11111111, 4'b0000, 12'd4);
        checkOutput("sw_mis_err", 32'(mis_seen), 32'd1);
        doLoad("sw_mis_rb", 32'h10, F3_LW, 32'h80FF1234);
`else
        doLoad("lw_mis", 32'h11, F3_LW, 32'h80FF1234);
        doLoad("lhu_11", 32'h11, F3_LHU, 32'h00001234);
`endif

        // Reset while a load sits in READ_WAIT must drop the response.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_func3 = F3_LW;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checkOutput("mid_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_ready", 32'(req_ready), 32'd1);
        checkOutput("mid_en", 32'(bram_en), 32'd0);
        checkOutput("mid_stall_rst", 32'(stall), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("mid_rsp", 32'(rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("post_rsp", 32'(rsp_valid), 32'd0);
        end
        doLoad("post_lw", 32'h10, F3_LW, 32'h80FF1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
